// File: rtl/conv_tile_scheduler.sv
// Layer-level tile walker for the convolution engine: sequences out_fm load, in_fm/weight loads, conv and out_fm store.
// Optional CONV_SCHED_PERF_EN adds saturating busy/conv cycle counters.
module conv_tile_scheduler #(
  parameter int AW     = 16,
  parameter int IN_CH  = 64,
  parameter int OUT_CH = 64,
  parameter int ROW    = 128,
  parameter int COL    = 32,
  parameter int Tm     = 16,
  parameter int Tn     = 16,
  parameter int Tr     = 64,
  parameter int Tc     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          layer_start,
  output logic          layer_done,
  output logic          busy,
  output logic          out_fm_load_start,
  input  logic          out_fm_load_done,
  output logic          in_fm_load_start,
  input  logic          in_fm_load_done,
  output logic          weight_load_start,
  input  logic          weight_load_done,
  output logic          conv_computing_start,
  input  logic          conv_computing_done,
  output logic          out_fm_store_start,
  input  logic          out_fm_store_done,
  output logic [AW-1:0] tile_row,
  output logic [AW-1:0] tile_col,
  output logic [AW-1:0] tile_in_ch,
  output logic [AW-1:0] tile_out_ch
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]   perf_busy_cycles,
  output logic [31:0]   perf_conv_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, OUT_LD, IN_LD, CONV, OUT_ST} state_t;

  localparam logic [AW-1:0] IC_LAST  = AW'(IN_CH - Tm);
  localparam logic [AW-1:0] OC_LAST  = AW'(OUT_CH - Tn);
  localparam logic [AW-1:0] ROW_LAST = AW'(ROW - Tr);
  localparam logic [AW-1:0] COL_LAST = AW'(COL - Tc);
  localparam logic [AW-1:0] TM_STEP  = AW'(Tm);
  localparam logic [AW-1:0] TN_STEP  = AW'(Tn);
  localparam logic [AW-1:0] TR_STEP  = AW'(Tr);
  localparam logic [AW-1:0] TC_STEP  = AW'(Tc);

  state_t state;
  logic   in_flag;
  logic   w_flag;
  logic   last_tile;

  assign busy      = (state != IDLE);
  assign last_tile = (tile_col == COL_LAST) && (tile_row == ROW_LAST) && (tile_out_ch == OC_LAST);

  // Start pulses are registered alongside the state change so each is high only in the first cycle of its state
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      layer_done           <= 1'b0;
      out_fm_load_start    <= 1'b0;
      in_fm_load_start     <= 1'b0;
      weight_load_start    <= 1'b0;
      conv_computing_start <= 1'b0;
      out_fm_store_start   <= 1'b0;
      in_flag              <= 1'b0;
      w_flag               <= 1'b0;
      tile_row             <= '0;
      tile_col             <= '0;
      tile_in_ch           <= '0;
      tile_out_ch          <= '0;
    end else begin
      layer_done           <= 1'b0;
      out_fm_load_start    <= 1'b0;
      in_fm_load_start     <= 1'b0;
      weight_load_start    <= 1'b0;
      conv_computing_start <= 1'b0;
      out_fm_store_start   <= 1'b0;
      case (state)
        IDLE: begin
          if (layer_start) begin
            state             <= OUT_LD;
            out_fm_load_start <= 1'b1;
          end
        end
        OUT_LD: begin
          if (out_fm_load_done) begin
            state             <= IN_LD;
            in_fm_load_start  <= 1'b1;
            weight_load_start <= 1'b1;
          end
        end
        // The two load dones may come in either order, so each is remembered until both are seen
        IN_LD: begin
          if ((in_fm_load_done || in_flag) && (weight_load_done || w_flag)) begin
            state                <= CONV;
            conv_computing_start <= 1'b1;
            in_flag              <= 1'b0;
            w_flag               <= 1'b0;
          end else begin
            if (in_fm_load_done)  in_flag <= 1'b1;
            if (weight_load_done) w_flag  <= 1'b1;
          end
        end
        CONV: begin
          if (conv_computing_done) begin
            if (tile_in_ch < IC_LAST) begin
              tile_in_ch        <= tile_in_ch + TM_STEP;
              state             <= IN_LD;
              in_fm_load_start  <= 1'b1;
              weight_load_start <= 1'b1;
            end else begin
              tile_in_ch         <= '0;
              state              <= OUT_ST;
              out_fm_store_start <= 1'b1;
            end
          end
        end
        // Nested col/row/out_ch advance; on the last tile every index wraps back to 0
        OUT_ST: begin
          if (out_fm_store_done) begin
            if (tile_col != COL_LAST) begin
              tile_col <= tile_col + TC_STEP;
            end else begin
              tile_col <= '0;
              if (tile_row != ROW_LAST) begin
                tile_row <= tile_row + TR_STEP;
              end else begin
                tile_row <= '0;
                if (tile_out_ch != OC_LAST) tile_out_ch <= tile_out_ch + TN_STEP;
                else                        tile_out_ch <= '0;
              end
            end
            if (last_tile) begin
              state      <= IDLE;
              layer_done <= 1'b1;
            end else begin
              state             <= OUT_LD;
              out_fm_load_start <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV_SCHED_PERF_EN
  // Counters restart on an accepted layer_start and hold their value once the layer returns to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cycles <= '0;
      perf_conv_cycles <= '0;
    end else if (state == IDLE && layer_start) begin
      perf_busy_cycles <= '0;
      perf_conv_cycles <= '0;
    end else begin
      if (busy && perf_busy_cycles != 32'hFFFF_FFFF)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (state == CONV && perf_conv_cycles != 32'hFFFF_FFFF)
        perf_conv_cycles <= perf_conv_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler: 32x32x128x32 layer with modelled load/conv/store units plus a single-tile instance.
// Define CONV_SCHED_PERF_EN to also check the performance counters.
module tb_conv_tile_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        layer_start;
  logic        layer_done, busy;
  logic        out_fm_load_start, in_fm_load_start, weight_load_start;
  logic        conv_computing_start, out_fm_store_start;
  logic        out_fm_load_done, in_fm_load_done, weight_load_done;
  logic        conv_computing_done, out_fm_store_done;
  logic [15:0] tile_row, tile_col, tile_in_ch, tile_out_ch;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_busy_cycles, perf_conv_cycles;
`endif

  // unit index: 0 out_fm load, 1 in_fm load, 2 weight load, 3 conv, 4 out_fm store
  logic [4:0] start_v;
  logic [4:0] auto_done;
  logic [4:0] man_done;
  logic [4:0] auto_en;
  int         lat [5];
  int         cnt [5];

  assign start_v             = {out_fm_store_start, conv_computing_start, weight_load_start,
                                in_fm_load_start, out_fm_load_start};
  assign out_fm_load_done    = auto_done[0] | man_done[0];
  assign in_fm_load_done     = auto_done[1] | man_done[1];
  assign weight_load_done    = auto_done[2] | man_done[2];
  assign conv_computing_done = auto_done[3] | man_done[3];
  assign out_fm_store_done   = auto_done[4] | man_done[4];

  conv_tile_scheduler #(
    .AW(16), .IN_CH(32), .OUT_CH(32), .ROW(128), .COL(32),
    .Tm(16), .Tn(16), .Tr(64), .Tc(16)
  ) u_dut (
    .clk(clk), .rst(rst), .layer_start(layer_start), .layer_done(layer_done), .busy(busy),
    .out_fm_load_start(out_fm_load_start), .out_fm_load_done(out_fm_load_done),
    .in_fm_load_start(in_fm_load_start), .in_fm_load_done(in_fm_load_done),
    .weight_load_start(weight_load_start), .weight_load_done(weight_load_done),
    .conv_computing_start(conv_computing_start), .conv_computing_done(conv_computing_done),
    .out_fm_store_start(out_fm_store_start), .out_fm_store_done(out_fm_store_done),
    .tile_row(tile_row), .tile_col(tile_col), .tile_in_ch(tile_in_ch), .tile_out_ch(tile_out_ch)
`ifdef CONV_SCHED_PERF_EN
    , .perf_busy_cycles(perf_busy_cycles), .perf_conv_cycles(perf_conv_cycles)
`endif
  );

  // Single-tile instance with units that answer one cycle after each start
  logic        s_layer_start, s_layer_done, s_busy;
  logic        s_out_start, s_in_start, s_w_start, s_conv_start, s_st_start;
  logic        s_out_done, s_in_done, s_w_done, s_conv_done, s_st_done;
  logic [15:0] s_row, s_col, s_ic, s_oc;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0] s_perf_busy, s_perf_conv;
`endif

  conv_tile_scheduler #(
    .AW(16), .IN_CH(16), .OUT_CH(16), .ROW(64), .COL(16),
    .Tm(16), .Tn(16), .Tr(64), .Tc(16)
  ) u_single (
    .clk(clk), .rst(rst), .layer_start(s_layer_start), .layer_done(s_layer_done), .busy(s_busy),
    .out_fm_load_start(s_out_start), .out_fm_load_done(s_out_done),
    .in_fm_load_start(s_in_start), .in_fm_load_done(s_in_done),
    .weight_load_start(s_w_start), .weight_load_done(s_w_done),
    .conv_computing_start(s_conv_start), .conv_computing_done(s_conv_done),
    .out_fm_store_start(s_st_start), .out_fm_store_done(s_st_done),
    .tile_row(s_row), .tile_col(s_col), .tile_in_ch(s_ic), .tile_out_ch(s_oc)
`ifdef CONV_SCHED_PERF_EN
    , .perf_busy_cycles(s_perf_busy), .perf_conv_cycles(s_perf_conv)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_out_ld, n_in_ld, n_w_ld, n_conv, n_st, n_done, busy_cnt;
  int s_n_out, s_n_in, s_n_w, s_n_conv, s_n_st, s_n_done;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Unit models: done pulses so the DUT samples it lat cycles after the start pulse cycle
  initial begin
    auto_done = '0;
    for (int u = 0; u < 5; u++) cnt[u] = 0;
  end
  always @(negedge clk) begin
    for (int u = 0; u < 5; u++) begin
      auto_done[u] = 1'b0;
      if (cnt[u] > 0) begin
        cnt[u]--;
        if (cnt[u] == 0) auto_done[u] = 1'b1;
      end
      if (start_v[u] && auto_en[u]) begin
        if (lat[u] <= 1) auto_done[u] = 1'b1;
        else             cnt[u] = lat[u] - 1;
      end
    end
  end

  always @(negedge clk) begin
    s_out_done  = s_out_start;
    s_in_done   = s_in_start;
    s_w_done    = s_w_start;
    s_conv_done = s_conv_start;
    s_st_done   = s_st_start;
  end

  // Pulse counting and index sequencing, sampled 1 time unit after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
    if (out_fm_load_start) begin
      checkOutput("idx_ld_oc",  32'(tile_out_ch), 32'((n_out_ld / 4) * 16));
      checkOutput("idx_ld_row", 32'(tile_row),    32'(((n_out_ld / 2) % 2) * 64));
      checkOutput("idx_ld_col", 32'(tile_col),    32'((n_out_ld % 2) * 16));
      checkOutput("idx_ld_ic",  32'(tile_in_ch),  32'd0);
      n_out_ld++;
    end
    if (in_fm_load_start) begin
      checkOutput("ld_together", 32'(weight_load_start), 32'd1);
      n_in_ld++;
    end
    if (weight_load_start) n_w_ld++;
    if (conv_computing_start) begin
      checkOutput("idx_conv_ic", 32'(tile_in_ch), 32'((n_conv % 2) * 16));
      n_conv++;
    end
    if (out_fm_store_start) begin
      checkOutput("idx_st_oc",  32'(tile_out_ch), 32'((n_st / 4) * 16));
      checkOutput("idx_st_row", 32'(tile_row),    32'(((n_st / 2) % 2) * 64));
      checkOutput("idx_st_col", 32'(tile_col),    32'((n_st % 2) * 16));
      n_st++;
    end
    if (layer_done) begin
      checkOutput("done_idx_zero", 32'({tile_out_ch, tile_row} | {tile_col, tile_in_ch}), 32'd0);
      checkOutput("done_after_st", 32'(out_fm_store_done), 32'd1);
      checkOutput("done_nstores", 32'(n_st), 32'd8);
      n_done++;
    end
    if (s_out_start)  s_n_out++;
    if (s_in_start)   s_n_in++;
    if (s_w_start)    s_n_w++;
    if (s_conv_start) s_n_conv++;
    if (s_st_start)   s_n_st++;
    if (s_layer_done) s_n_done++;
  end

  task automatic clearCounts();
    n_out_ld = 0; n_in_ld = 0; n_w_ld = 0; n_conv = 0; n_st = 0; n_done = 0; busy_cnt = 0;
    s_n_out = 0; s_n_in = 0; s_n_w = 0; s_n_conv = 0; s_n_st = 0; s_n_done = 0;
  endtask

  task automatic applyStimulus(input int sel);
    @(negedge clk);
    if (sel == 0) layer_start = 1'b1;
    else          s_layer_start = 1'b1;
    @(negedge clk);
    layer_start   = 1'b0;
    s_layer_start = 1'b0;
  endtask

  task automatic waitSig(input int sel, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(posedge clk);
      #1;
      case (sel)
        0:       got = out_fm_load_start;
        1:       got = in_fm_load_start;
        3:       got = conv_computing_start;
        5:       got = layer_done;
        default: got = s_layer_done;
      endcase
    end
    checkOutput(tag, 32'(got), 32'd1);
  endtask

  task automatic checkLayerCounts(input string tag);
    repeat (2) @(negedge clk);
    checkOutput({tag, "_n_out_ld"}, 32'(n_out_ld), 32'd8);
    checkOutput({tag, "_n_in_ld"},  32'(n_in_ld),  32'd16);
    checkOutput({tag, "_n_w_ld"},   32'(n_w_ld),   32'd16);
    checkOutput({tag, "_n_conv"},   32'(n_conv),   32'd16);
    checkOutput({tag, "_n_st"},     32'(n_st),     32'd8);
    checkOutput({tag, "_n_done"},   32'(n_done),   32'd1);
    checkOutput({tag, "_busy_end"}, 32'(busy),     32'd0);
  endtask

  initial begin
    rst = 1'b1; layer_start = 1'b0; s_layer_start = 1'b0;
    man_done = '0; auto_en = '1;
    lat[0] = 5; lat[1] = 5; lat[2] = 5; lat[3] = 5; lat[4] = 5;
    clearCounts();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pulses", 32'({layer_done, out_fm_load_start, in_fm_load_start, weight_load_start,
                                   conv_computing_start, out_fm_store_start}), 32'd0);
    checkOutput("rst_idx", 32'({tile_out_ch, tile_row} | {tile_col, tile_in_ch}), 32'd0);
    checkOutput("rst_single_busy", 32'(s_busy), 32'd0);
`ifdef CONV_SCHED_PERF_EN
    checkOutput("rst_perf", perf_busy_cycles | perf_conv_cycles, 32'd0);
`endif

    $display("[TB] test 1: full layer, latency 5");
    clearCounts();
    applyStimulus(0);
    checkOutput("t1_start_lat", 32'(out_fm_load_start), 32'd1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    waitSig(5, "t1_layer_done");
    checkLayerCounts("t1");

    $display("[TB] test 2: separated and simultaneous load dones");
    clearCounts();
    auto_en[1] = 1'b0;
    auto_en[2] = 1'b0;
    applyStimulus(0);
    waitSig(1, "t2_first_in_ld");
    @(negedge clk); man_done[2] = 1'b1;
    @(negedge clk); man_done[2] = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("t2_no_early_conv", 32'(n_conv), 32'd0);
    man_done[1] = 1'b1;
    @(posedge clk); #1;
    checkOutput("t2_gap_conv_lat", 32'(conv_computing_start), 32'd1);
    @(negedge clk); man_done[1] = 1'b0;
    waitSig(1, "t2_second_in_ld");
    @(negedge clk);
    checkOutput("t2_no_early_conv2", 32'(n_conv), 32'd1);
    man_done[1] = 1'b1; man_done[2] = 1'b1;
    @(posedge clk); #1;
    checkOutput("t2_same_conv_lat", 32'(conv_computing_start), 32'd1);
    @(negedge clk);
    man_done[1] = 1'b0; man_done[2] = 1'b0;
    auto_en[1] = 1'b1; auto_en[2] = 1'b1;
    checkOutput("t2_conv_once", 32'(n_conv), 32'd2);
    waitSig(5, "t2_layer_done");
    checkLayerCounts("t2");

    $display("[TB] test 3: ignored events");
    clearCounts();
    applyStimulus(0);
    @(negedge clk); man_done[3] = 1'b1;
    @(negedge clk); man_done[3] = 1'b0;
    checkOutput("t3_no_conv_start", 32'(n_conv), 32'd0);
    checkOutput("t3_no_in_ld", 32'(n_in_ld), 32'd0);
    waitSig(3, "t3_conv");
    @(negedge clk); layer_start = 1'b1;
    @(negedge clk); layer_start = 1'b0;
    checkOutput("t3_still_one_ld", 32'(n_out_ld), 32'd1);
    waitSig(5, "t3_layer_done");
    checkLayerCounts("t3");

    $display("[TB] test 4: reset mid-CONV");
    clearCounts();
    applyStimulus(0);
    waitSig(3, "t4_conv");
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checkOutput("t4_busy", 32'(busy), 32'd0);
    checkOutput("t4_idx", 32'({tile_out_ch, tile_row} | {tile_col, tile_in_ch}), 32'd0);
    checkOutput("t4_pulses", 32'({layer_done, out_fm_load_start, in_fm_load_start,
                                  conv_computing_start, out_fm_store_start}), 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("t4_idle_after", 32'(busy), 32'd0);
    clearCounts();
    applyStimulus(0);
    waitSig(5, "t4_layer_done");
    checkLayerCounts("t4");

    $display("[TB] test 5: single-tile layer, back to back");
    clearCounts();
    applyStimulus(1);
    waitSig(6, "t5_done1");
    @(negedge clk);
    checkOutput("t5_out1",  32'(s_n_out),  32'd1);
    checkOutput("t5_in1",   32'(s_n_in),   32'd1);
    checkOutput("t5_w1",    32'(s_n_w),    32'd1);
    checkOutput("t5_conv1", 32'(s_n_conv), 32'd1);
    checkOutput("t5_st1",   32'(s_n_st),   32'd1);
    checkOutput("t5_done1_cnt", 32'(s_n_done), 32'd1);
    s_layer_start = 1'b1;
    @(negedge clk); s_layer_start = 1'b0;
    checkOutput("t5_b2b_start", 32'(s_out_start), 32'd1);
    waitSig(6, "t5_done2");
    @(negedge clk);
    checkOutput("t5_conv2", 32'(s_n_conv), 32'd2);
    checkOutput("t5_st2",   32'(s_n_st),   32'd2);
    checkOutput("t5_done2_cnt", 32'(s_n_done), 32'd2);
    checkOutput("t5_idx", 32'({s_oc, s_row} | {s_col, s_ic}), 32'd0);

`ifdef CONV_SCHED_PERF_EN
    $display("[TB] test 6: performance counters");
    lat[3] = 100;
    clearCounts();
    applyStimulus(0);
    waitSig(5, "t6_layer_done");
    checkLayerCounts("t6");
    checkOutput("t6_perf_conv", perf_conv_cycles, 32'd1600);
    checkOutput("t6_perf_busy", perf_busy_cycles, 32'(busy_cnt));
    repeat (5) @(negedge clk);
    checkOutput("t6_perf_hold", perf_conv_cycles, 32'd1600);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
